daisy_chain_requester: RTL and testbench
========================================

// Module: daisy_chain_requester
// PURPOSE
//  Agent-side controller for one slot of the daisy-chain arbiter. Takes a burst command from the local
//  agent, drives the arbiter cell request r, waits for grant g, issues one beat per granted cycle, and
//  releases r when the burst completes. Preemption (g dropping because upstream took priority) is handled
//  by pausing and re-requesting. One instance per chain slot, wired r -> cell R, cell G -> g.
// PARAMETERS
//  LEN_W    4   width of burst-length field; max burst = 2**LEN_W-1 beats
//  TIMEOUT  15  max consecutive ungranted cycles in REQ before abort (used only with REQ_TIMEOUT_EN)
// PORTS
//  clk      in   1      clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      burst command strobe, sampled at clk edge
//  len      in   LEN_W  beats in burst, sampled with start
//  g        in   1      grant from arbiter cell (combinational cin&r, may drop any cycle)
//  r        out  1      request to arbiter cell
//  busy     out  1      high in any state other than IDLE
//  beat     out  1      bus-owned beat strobe this cycle
//  done     out  1      one-cycle pulse, burst completed
//  timeout  out  1      one-cycle pulse, burst aborted on wait timeout
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE, remaining=0, wait_cnt=0; r=busy=beat=done=timeout=0.
//  - States: IDLE, REQ, XFER, DONE. r=1 in REQ and XFER only (registered decode). busy=(state!=IDLE).
//  - IDLE: start=1 & len!=0 -> REQ, remaining<=len. start with len==0 ignored. start outside IDLE ignored.
//  - REQ: edge with g=1 -> XFER; g=0 -> stay, wait_cnt increments.
//  - XFER: beat = (state==XFER) & g (Mealy, only combinational output). Edge with beat=1:
//    remaining-1; if remaining==1 -> DONE. Edge with g=0 (preempted) -> REQ, remaining unchanged,
//    wait_cnt<=0. Beats count only on edges where beat=1.
//  - DONE: done=1 (Moore), r=0; next edge -> IDLE. start in DONE ignored.
//  - Latency with g continuously 1: start at edge t -> r=1 after t; beats on edges t+2..t+1+len;
//    done high during cycle after last beat; r low from that cycle; new start accepted at the edge
//    following DONE.
//  - wait_cnt: cleared on entry to REQ, counts ungranted REQ cycles, saturates at TIMEOUT; width $clog2(TIMEOUT+1).
//  - remaining is LEN_W bits, never wraps: decrements only from >=1; reaching 0 coincides with DONE.
//  - Reset mid-burst: r drops asynchronously, burst lost, no done/timeout pulse.
// CONFIGURATION
//  REQ_TIMEOUT_EN defined: in REQ, edge with g=0 and wait_cnt==TIMEOUT-1 -> IDLE, timeout=1 for one
//    cycle (registered pulse alongside IDLE), r=0, remaining discarded, no done. A grant on that same
//    edge wins (-> XFER, no timeout).
//  REQ_TIMEOUT_EN undefined: requester waits indefinitely; timeout tied 0; wait_cnt logic absent.
// STRUCTURE
//  - Package daisy_req_pkg: state typedef enum logic[1:0] {IDLE,REQ,XFER,DONE}; LEN_W default constant.
//  - Single module; no sub-module needed (counters inline). Chain-level use instantiates N requesters
//    beside N arbiter cells.
// TESTING
//  Bench wires r/g through an ArbiterCell instance; bench drives cell cin.
//  1 Reset 3 cycles, cin=1, start len=3 -> r=1 next cycle, beat on 3 consecutive edges, done 1 cycle, r=0, busy=0.
//  2 cin=0 for 5 cycles after start len=2 -> r=1, beat=0, stays REQ; cin=1 -> 2 beats then done.
//  3 Preempt: len=4, drop cin after 2 beats for 3 cycles -> beat=0, r stays 1; cin=1 -> 2 more beats, done (4 total).
//  4 start len=0 -> no r, busy=0; start len=5 while busy -> ignored, exactly original beats.
//  5 rst_n low mid-XFER (asynchronous, between edges) -> r, beat, busy 0 immediately; after release idle until start.
//  6 REQ_TIMEOUT_EN, TIMEOUT=15, cin=0: start -> timeout pulse after 15 ungranted cycles, r=0, no done;
//    repeat with cin rising on cycle 15 -> XFER, no timeout.

Source files
------------

// File: rtl/daisy_chain_requester_pkg.sv
// Shared types and defaults for the daisy-chain requester.
// Package daisy_req_pkg: controller state encoding and default burst-length width.
package daisy_req_pkg;

   localparam int LEN_W_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      XFER = 2'd2,
      DONE = 2'd3
   } state_e;

endpackage : daisy_req_pkg

// File: rtl/daisy_chain_requester_if.sv
// Agent/arbiter-facing signal bundle of one daisy-chain requester slot.
// slave  : the requester itself (takes commands and grant, drives request and status).
// master : the local agent plus arbiter cell side (drives command and grant).
interface daisy_chain_requester_if
   import daisy_req_pkg::*;
#(
   parameter int LEN_W = LEN_W_DEF
) ();

   logic             start;
   logic [LEN_W-1:0] len;
   logic             g;
   logic             r;
   logic             busy;
   logic             beat;
   logic             done;
   logic             timeout;

   modport slave (
      input  start, len, g,
      output r, busy, beat, done, timeout
   );

   modport master (
      output start, len, g,
      input  r, busy, beat, done, timeout
   );

endinterface : daisy_chain_requester_if

// File: rtl/daisy_chain_requester.sv
// Agent-side controller for one slot of the daisy-chain arbiter: requests the bus,
// issues one beat per granted cycle, pauses and re-requests when preempted, and
// releases the request once the burst completes.
// Optional feature macro REQ_TIMEOUT_EN: abort a request after TIMEOUT consecutive
// ungranted cycles and pulse timeout; without it the requester waits indefinitely.
module daisy_chain_requester
   import daisy_req_pkg::*;
#(
   parameter int LEN_W   = LEN_W_DEF
`ifdef REQ_TIMEOUT_EN
  ,parameter int TIMEOUT = 15
`endif
) (
   input logic                    clk,
   input logic                    rst_n,
   daisy_chain_requester_if.slave bus
);

   state_e           state_q, state_d;
   logic [LEN_W-1:0] remaining_q, remaining_d;
   logic             r_q;

`ifdef REQ_TIMEOUT_EN
   localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);

   logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic              timeout_q, timeout_d;
`endif

   // Beat is the only combinational (Mealy) output: a transfer cycle that is granted right now.
   assign bus.beat = (state_q == XFER) && bus.g;
   assign bus.r    = r_q;
   assign bus.busy = (state_q != IDLE);
   assign bus.done = (state_q == DONE);
`ifdef REQ_TIMEOUT_EN
   assign bus.timeout = timeout_q;
`else
   assign bus.timeout = 1'b0;
`endif

   // Next-state, burst counter and wait counter decode.
   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
      state_d     = state_q;
      remaining_d = remaining_q;
`ifdef REQ_TIMEOUT_EN
      wait_cnt_d  = wait_cnt_q;
      timeout_d   = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // A zero-length command carries no work and is dropped.
            if (bus.start && (bus.len != '0)) begin
               state_d     = REQ;
               remaining_d = bus.len;
`ifdef REQ_TIMEOUT_EN
               wait_cnt_d  = '0;
`endif
            end
         end
         REQ: begin
            // A grant on the final waiting edge still wins over the abort.
            if (bus.g) begin
               state_d = XFER;
            end
`ifdef REQ_TIMEOUT_EN
            else if (wait_cnt_q == WAIT_LAST) begin
               state_d     = IDLE;
               remaining_d = '0;
               timeout_d   = 1'b1;
            end else if (wait_cnt_q != WAIT_MAX) begin
               wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
`endif
         end
         XFER: begin
            if (bus.g) begin
               // Remaining is at least 1 in XFER; the guard keeps the counter from ever wrapping.
               if (remaining_q != '0) begin
                  remaining_d = remaining_q - LEN_W'(1);
               end
               if (remaining_q == LEN_W'(1)) begin
                  state_d = DONE;
               end
            end else begin
               // Preempted by an upstream slot: keep the count and ask again.
               state_d = REQ;
`ifdef REQ_TIMEOUT_EN
               wait_cnt_d = '0;
`endif
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; request is a registered decode of the next state so it never glitches.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         r_q         <= 1'b0;
`ifdef REQ_TIMEOUT_EN
         wait_cnt_q  <= '0;
         timeout_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         state_q     <= state_d;
         remaining_q <= remaining_d;
         r_q         <= (state_d == REQ) || (state_d == XFER);
`ifdef REQ_TIMEOUT_EN
         wait_cnt_q  <= wait_cnt_d;
         timeout_q   <= timeout_d;
`endif
      end
   end

endmodule : daisy_chain_requester

// File: tb/tb_daisy_chain_requester.sv
// Self-checking bench for daisy_chain_requester. The request/grant pair runs through a
// behavioural arbiter cell (g = cin & r) whose chain input cin the bench drives.
// Stimulus pushes the expected output events (kind, cycle, r) into a scoreboard queue;
// a monitor pops and compares whenever the DUT shows beat, done or timeout.
// Timeout scenarios are exercised when REQ_TIMEOUT_EN is defined.
module tb_daisy_chain_requester;

   typedef enum int {EV_BEAT = 0, EV_DONE = 1, EV_TIMEOUT = 2} ev_e;

   typedef struct {
      ev_e  kind;
      int   cyc;
      logic r;
   } exp_t;

   logic clk;
   logic rst_n;
   logic cin;
   int   cyc;
   int   n_checks;
   int   n_pass;
   exp_t sb[$];

   daisy_chain_requester_if #(.LEN_W(4)) bus ();

   daisy_chain_requester #(
      .LEN_W   (4)
`ifdef REQ_TIMEOUT_EN
     ,.TIMEOUT (15)
`endif
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Arbiter cell: grant passes through when the chain input is free and this slot requests.
   assign bus.g = cin & bus.r;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic expect_ev(input ev_e kind, input int at, input logic r);
      exp_t e;
      e.kind = kind;
      e.cyc  = at;
      e.r    = r;
      sb.push_back(e);
   endtask

   // Caller is at posedge+1; k is the cycle count at issue, returns at the next posedge+1.
   task automatic issue_start(input int l, output int k);
      k         = cyc;
      bus.start = 1'b1;
      bus.len   = 4'(l);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.busy && (n < budget));
      check(name, int'(bus.busy), 0);
   endtask

   task automatic drain_check(input string name);
      @(negedge clk);
      check(name, sb.size(), 0);
      check({name, "_r"}, int'(bus.r), 0);
      sb.delete();
   endtask

   // Scoreboard monitor: sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin : monitor
      exp_t e;
      ev_e  got;
      int   hits;
      if (rst_n && (bus.beat || bus.done || bus.timeout)) begin
         hits = int'(bus.beat) + int'(bus.done) + int'(bus.timeout);
         check("one_event", hits, 1);
         got = bus.beat ? EV_BEAT : (bus.done ? EV_DONE : EV_TIMEOUT);
         if (sb.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required no event", int'(got), cyc);
         end else begin
            e = sb.pop_front();
            check("ev_kind", int'(got), int'(e.kind));
            check("ev_cycle", cyc, e.cyc);
            check("ev_r", int'(bus.r), int'(e.r));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      cyc       = 0;
      n_checks  = 0;
      n_pass    = 0;
      rst_n     = 1'b0;
      cin       = 1'b1;
      bus.start = 1'b0;
      bus.len   = '0;

      // 1: reset state, then straight burst of 3 with a free chain.
      repeat (3) begin
         @(negedge clk);
         check("rst_r", int'(bus.r), 0);
         check("rst_busy", int'(bus.busy), 0);
         check("rst_beat", int'(bus.beat), 0);
         check("rst_done", int'(bus.done), 0);
         check("rst_timeout", int'(bus.timeout), 0);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      expect_ev(EV_BEAT, cyc + 2, 1'b1);
      expect_ev(EV_BEAT, cyc + 3, 1'b1);
      expect_ev(EV_BEAT, cyc + 4, 1'b1);
      expect_ev(EV_DONE, cyc + 5, 1'b0);
      issue_start(3, k);
      check("t1_r_after_start", int'(bus.r), 1);
      check("t1_busy_after_start", int'(bus.busy), 1);
      check("t1_no_beat_in_req", int'(bus.beat), 0);
      wait_idle("t1_idle", 20);
      drain_check("t1_sb_empty");

      // 2: chain blocked for 5 cycles, then released.
      @(posedge clk); #1;
      cin = 1'b0;
      expect_ev(EV_BEAT, cyc + 7, 1'b1);
      expect_ev(EV_BEAT, cyc + 8, 1'b1);
      expect_ev(EV_DONE, cyc + 9, 1'b0);
      issue_start(2, k);
      repeat (5) begin
         @(negedge clk);
         check("t2_r_waiting", int'(bus.r), 1);
         check("t2_beat_waiting", int'(bus.beat), 0);
         check("t2_busy_waiting", int'(bus.busy), 1);
      end
      @(posedge clk); #1;
      cin = 1'b1;
      wait_idle("t2_idle", 20);
      drain_check("t2_sb_empty");

      // 3: preempted after 2 of 4 beats for 3 cycles.
      @(posedge clk); #1;
      expect_ev(EV_BEAT, cyc + 2, 1'b1);
      expect_ev(EV_BEAT, cyc + 3, 1'b1);
      expect_ev(EV_BEAT, cyc + 8, 1'b1);
      expect_ev(EV_BEAT, cyc + 9, 1'b1);
      expect_ev(EV_DONE, cyc + 10, 1'b0);
      issue_start(4, k);
      repeat (3) @(posedge clk);
      #1;
      cin = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t3_r_preempted", int'(bus.r), 1);
         check("t3_beat_preempted", int'(bus.beat), 0);
      end
      @(posedge clk); #1;
      cin = 1'b1;
      wait_idle("t3_idle", 20);
      drain_check("t3_sb_empty");

      // 4: zero-length start ignored; start while busy (and in DONE) ignored.
      @(posedge clk); #1;
      issue_start(0, k);
      @(negedge clk);
      check("t4_len0_busy", int'(bus.busy), 0);
      check("t4_len0_r", int'(bus.r), 0);
      @(posedge clk); #1;
      k = cyc;
      expect_ev(EV_BEAT, k + 2, 1'b1);
      expect_ev(EV_BEAT, k + 3, 1'b1);
      expect_ev(EV_DONE, k + 4, 1'b0);
      bus.start = 1'b1;
      bus.len   = 4'd2;
      @(posedge clk); #1;
      bus.len = 4'd5;
      repeat (4) @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("t4_idle_after_done", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      check("t4_still_idle", int'(bus.busy), 0);
      drain_check("t4_sb_empty");

      // 5: asynchronous reset in the middle of a transfer.
      @(posedge clk); #1;
      expect_ev(EV_BEAT, cyc + 2, 1'b1);
      expect_ev(EV_BEAT, cyc + 3, 1'b1);
      issue_start(6, k);
      repeat (3) @(negedge clk);
      #2;
      check("t5_pre_rst_beat", int'(bus.beat), 1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_r", int'(bus.r), 0);
      check("t5_rst_beat", int'(bus.beat), 0);
      check("t5_rst_busy", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("t5_post_rst_busy", int'(bus.busy), 0);
         check("t5_post_rst_r", int'(bus.r), 0);
      end
      drain_check("t5_sb_empty");

`ifdef REQ_TIMEOUT_EN
      // 6a: never granted -> abort after 15 ungranted cycles.
      @(posedge clk); #1;
      cin = 1'b0;
      expect_ev(EV_TIMEOUT, cyc + 16, 1'b0);
      issue_start(3, k);
      wait_idle("t6a_idle", 40);
      drain_check("t6a_sb_empty");

      // 6b: grant arrives on the would-be abort edge -> transfer wins.
      @(posedge clk); #1;
      expect_ev(EV_BEAT, cyc + 16, 1'b1);
      expect_ev(EV_DONE, cyc + 17, 1'b0);
      issue_start(1, k);
      repeat (14) @(posedge clk);
      #1;
      check("t6b_still_req", int'(bus.r), 1);
      cin = 1'b1;
      wait_idle("t6b_idle", 40);
      drain_check("t6b_sb_empty");
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_daisy_chain_requester
